// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU: function codes, FSM states,
// slice width and a helper that tells which functions run through the subtractor.
package alu_pkg;

    localparam int NIB_W = 4;

    localparam logic [2:0] FUNC_ADD = 3'b000;
    localparam logic [2:0] FUNC_SUB = 3'b001;
    localparam logic [2:0] FUNC_NOT = 3'b010;
    localparam logic [2:0] FUNC_AND = 3'b011;
    localparam logic [2:0] FUNC_OR  = 3'b100;
    localparam logic [2:0] FUNC_XOR = 3'b101;
    localparam logic [2:0] FUNC_SLT = 3'b110;
    localparam logic [2:0] FUNC_EQ  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Compare ops are evaluated as an internal a-b, so they share the subtract path.
    function automatic logic uses_sub(input logic [2:0] func);
        return (func == FUNC_SUB) || (func == FUNC_SLT) || (func == FUNC_EQ);
    endfunction

endpackage

// File: rtl/alu4_slice.sv
// Combinational 4-bit ALU slice shared by every nibble pass.
// Exposes the carry into bit 3 so the top nibble can derive signed overflow.
module alu4_slice
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic [2:0] func,
    output logic [3:0] y,
    output logic       cout,
    output logic       c3
);

    logic [3:0] b_eff_s;
    logic [4:0] sum_s;
    logic [3:0] low_s;

    // Slice arithmetic/logic evaluation; carry outputs are forced low for logic ops.
    always_comb begin
        b_eff_s = uses_sub(func) ? ~b : b;
        sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {4'b0000, cin};
        low_s   = {1'b0, a[2:0]} + {1'b0, b_eff_s[2:0]} + {3'b000, cin};
        y       = 4'b0000;
        cout    = 1'b0;
        c3      = 1'b0;
        case (func)
            FUNC_ADD, FUNC_SUB, FUNC_SLT, FUNC_EQ: begin
                y    = sum_s[3:0];
                cout = sum_s[4];
                c3   = low_s[3];
            end
            FUNC_NOT: y = ~a;
            FUNC_AND: y = a & b;
            FUNC_OR:  y = a | b;
            FUNC_XOR: y = a ^ b;
            default:  y = 4'b0000;
        endcase
    end

endmodule

// File: rtl/alu_nibble_seq.sv
// Nibble-serial ALU controller: latches a request, walks the operands through
// one alu4_slice a nibble per clock, then presents a held response.
module alu_nibble_seq
    import alu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_func,
    input  logic [NIB_W*NIBBLES-1:0] req_a,
    input  logic [NIB_W*NIBBLES-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [NIB_W*NIBBLES-1:0] rsp_result,
    output logic                     rsp_cout,
    output logic                     rsp_overflow,
    output logic                     rsp_zero,
    output logic                     busy
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_r;
    state_t           state_nx_s;
    logic [2:0]       func_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [W-1:0]     res_r;
    logic [IDX_W-1:0] idx_r;
    logic             carry_r;

    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [3:0]       y_s;
    logic             cout_s;
    logic             c3_s;
    logic             last_s;
    logic             ovf_s;
    logic [W-1:0]     word_s;
    logic [W-1:0]     final_s;
    logic             fin_cout_s;
    logic             fin_ovf_s;

    alu4_slice u_slice (
        .a    (a_nib_s),
        .b    (b_nib_s),
        .cin  (carry_r),
        .func (func_r),
        .y    (y_s),
        .cout (cout_s),
        .c3   (c3_s)
    );

    // Select the operand nibbles for the current pass.
    always_comb begin
        a_nib_s = a_r[idx_r*NIB_W +: NIB_W];
        b_nib_s = b_r[idx_r*NIB_W +: NIB_W];
        last_s  = (idx_r == LAST_IDX);
    end

    // Merge this pass into the word; on the top nibble this is the full result.
    always_comb begin
        word_s                         = res_r;
        word_s[idx_r*NIB_W +: NIB_W]   = y_s;
        ovf_s                          = c3_s ^ cout_s;
        final_s                        = word_s;
        fin_cout_s                     = cout_s;
        fin_ovf_s                      = ovf_s;
        case (func_r)
            FUNC_ADD, FUNC_SUB: final_s = word_s;
            FUNC_SLT: final_s = {{(W-1){1'b0}}, word_s[W-1] ^ ovf_s};
            FUNC_EQ:  final_s = {{(W-1){1'b0}}, (word_s == {W{1'b0}})};
            default: begin
                fin_cout_s = 1'b0;
                fin_ovf_s  = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) state_nx_s = ST_RUN;
                else           state_nx_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_nx_s = ST_DONE;
                else        state_nx_s = ST_RUN;
            end
            ST_DONE: begin
                if (rsp_ready) state_nx_s = ST_IDLE;
                else           state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        case (state_r)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_RUN, ST_DONE: begin
                req_ready = 1'b0;
                busy      = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
                busy      = 1'b1;
            end
        endcase
    end

    // Operand latches, carry chain, result accumulation and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            func_r       <= 3'b000;
            a_r          <= {W{1'b0}};
            b_r          <= {W{1'b0}};
            res_r        <= {W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            carry_r      <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_result   <= {W{1'b0}};
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        func_r  <= req_func;
                        a_r     <= req_a;
                        b_r     <= req_b;
                        res_r   <= {W{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        carry_r <= uses_sub(req_func);
                    end
                end
                ST_RUN: begin
                    res_r   <= word_s;
                    carry_r <= cout_s;
                    idx_r   <= idx_r + 1'b1;
                    if (last_s) begin
                        rsp_valid    <= 1'b1;
                        rsp_result   <= final_s;
                        rsp_cout     <= fin_cout_s;
                        rsp_overflow <= fin_ovf_s;
                        rsp_zero     <= (final_s == {W{1'b0}});
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: rsp_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed + randomized bench for alu_nibble_seq, checked against a word-level model.
module tb_alu_nibble_seq;

    localparam int NIBBLES = 4;
    localparam int W       = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         rsp_ready = 1'b0;
    logic [2:0]   req_func = 3'b000;
    logic [W-1:0] req_a = 16'h0000;
    logic [W-1:0] req_b = 16'h0000;
    logic         req_ready;
    logic         rsp_valid;
    logic [W-1:0] rsp_result;
    logic         rsp_cout;
    logic         rsp_overflow;
    logic         rsp_zero;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_func     (req_func),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_cout     (rsp_cout),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word-level reference: plain arithmetic on whole operands.
    task automatic model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c, output logic v);
        logic [W:0]   s;
        logic [W-1:0] d;
        logic         sc;
        logic         sv;
        d  = a - b;
        sc = (a >= b);
        sv = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
        c  = 1'b0;
        v  = 1'b0;
        case (f)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd1: begin r = d; c = sc; v = sv; end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: begin r = ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000; c = sc; v = sv; end
            default: begin r = (a == b) ? 16'h0001 : 16'h0000; c = sc; v = sv; end
        endcase
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, W'(req_ready), 16'h0001);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_rsp(input string tag, input logic [2:0] f,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] er;
        logic         ec;
        logic         ev;
        model(f, a, b, er, ec, ev);
        chk({tag, "_result"}, rsp_result, er);
        chk({tag, "_cout"}, W'(rsp_cout), W'(ec));
        chk({tag, "_ovf"}, W'(rsp_overflow), W'(ev));
        chk({tag, "_zero"}, W'(rsp_zero), W'(er == 16'h0000));
    endtask

    task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        int lat;
        wait_ready(tag);
        req_valid = 1'b1;
        req_func  = f;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        req_func  = 3'($urandom);
        req_a     = W'($urandom);
        req_b     = W'($urandom);
        chk({tag, "_busy"}, W'(busy), 16'h0001);
        wait_rsp(lat);
        chk({tag, "_latency"}, W'(lat), W'(NIBBLES));
        check_rsp(tag, f, a, b);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_valid_clr"}, W'(rsp_valid), 16'h0000);
    endtask

    initial begin
        int           lat;
        logic [W-1:0] held;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("rst_ready", W'(req_ready), 16'h0001);
        chk("rst_busy", W'(busy), 16'h0000);
        chk("rst_valid", W'(rsp_valid), 16'h0000);
        chk("rst_result", rsp_result, 16'h0000);
        chk("rst_flags", {13'd0, rsp_cout, rsp_overflow, rsp_zero}, 16'h0000);
        @(negedge clk);

        run_op(3'd0, 16'h7FFF, 16'h0001, "add_ovf");
        run_op(3'd1, 16'h0000, 16'h0001, "sub_borrow");
        run_op(3'd1, 16'h1234, 16'h1234, "sub_zero");
        run_op(3'd6, 16'h8000, 16'h0001, "slt_neg");
        run_op(3'd6, 16'h0001, 16'h8000, "slt_pos");
        run_op(3'd7, 16'hABCD, 16'hABCD, "eq_same");
        run_op(3'd7, 16'hABCD, 16'hABCC, "eq_diff");
        run_op(3'd5, 16'hF0F0, 16'h0FF0, "xor");
        run_op(3'd2, 16'h00FF, 16'h1234, "not");
        run_op(3'd3, 16'hFF0F, 16'h0FF3, "and");
        run_op(3'd4, 16'h0A00, 16'h00B1, "or");

        // Backpressure: response must hold while a new request waits.
        wait_ready("bp");
        req_valid = 1'b1;
        req_func  = 3'd0;
        req_a     = 16'h1111;
        req_b     = 16'h2222;
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(lat);
        chk("bp_latency", W'(lat), W'(NIBBLES));
        check_rsp("bp_first", 3'd0, 16'h1111, 16'h2222);
        held      = rsp_result;
        req_valid = 1'b1;
        req_func  = 3'd1;
        req_a     = 16'h5000;
        req_b     = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_result", rsp_result, held);
            chk("bp_hold_valid", W'(rsp_valid), 16'h0001);
            chk("bp_no_ready", W'(req_ready), 16'h0000);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_idle_ready", W'(req_ready), 16'h0001);
        chk("bp_idle_valid", W'(rsp_valid), 16'h0000);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_second_busy", W'(busy), 16'h0001);
        wait_rsp(lat);
        chk("bp_second_latency", W'(lat), W'(NIBBLES));
        check_rsp("bp_second", 3'd1, 16'h5000, 16'h0001);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset two nibbles into an add that would leave a carry in flight.
        wait_ready("mid");
        req_valid = 1'b1;
        req_func  = 3'd0;
        req_a     = 16'hFFFF;
        req_b     = 16'h0001;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_busy", W'(busy), 16'h0000);
        chk("mid_rst_valid", W'(rsp_valid), 16'h0000);
        chk("mid_rst_ready", W'(req_ready), 16'h0001);
        run_op(3'd0, 16'h0001, 16'h0001, "add_after_rst");

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), W'($urandom), W'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Multi-cycle controller that runs W-bit ALU operations through one shared 4-bit ALU slice, one nibble per clock, chaining the carry between nibbles.
- Sits between a requester (CPU/test harness) and the 4-bit adder/logic datapath.
- Uses the same 3-bit func encoding as the existing 4-bit ALU.
- Uses a valid/ready request and response handshake.

Parameters:
- NIBBLES, 4, number of 4-bit passes; operand width W = 4*NIBBLES (default 16).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset, sampled on clk rising edge).
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_func  input  3  operation: 000 add, 001 sub, 010 not a, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal.
- req_a  input  W  operand a.
- req_b  input  W  operand b (ignored for not).
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_result  output  W  result word.
- rsp_cout  output  1  final carry out.
- rsp_overflow  output  1  signed overflow.
- rsp_zero  output  1  rsp_result == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to IDLE; the in-flight operation is discarded.
  - rsp_valid=0; rsp_result, rsp_cout, rsp_overflow, rsp_zero = 0; busy=0; nibble index and carry = 0.
  - req_ready=1 from the first cycle after reset.
  - Reset overrides every handshake in the same cycle.
- FSM states IDLE, RUN, DONE:
  - IDLE: req_ready=1. On req_valid & req_ready, latch func/a/b, set idx=0, go to RUN.
    - Initial carry is 1 for sub, slt and eq; 0 otherwise.
  - RUN: each edge processes nibble idx:
    - Slice inputs a[4idx+3:4idx] and b (inverted for sub/slt/eq) plus the carry.
    - Write the slice output into result nibble idx; register the carry; idx++.
    - On the edge with idx==NIBBLES-1, go to DONE and load all rsp_* outputs.
  - DONE: rsp_valid=1; outputs held stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE and clear rsp_valid.
- Latency and throughput:
  - rsp_valid rises exactly NIBBLES edges after the accept edge.
  - No overlap: req_ready=0 in RUN and DONE. Minimum spacing between accepts is NIBBLES+2 cycles.
- Arithmetic (add/sub):
  - cout = carry out of the top nibble (for sub, 1 = no borrow).
  - overflow = carry into bit W-1 XOR carry out of bit W-1.
- Logic ops (not/and/or/xor): bitwise per nibble; carry chain unused; cout=0, overflow=0.
- slt: internal subtract a-b. Result = {0..., N ^ V}, where N = bit W-1 of the difference.
- eq: internal subtract a-b. Result = {0..., difference==0}.
- Flags for slt/eq: rsp_cout and rsp_overflow report the internal subtraction.
- rsp_zero always reflects the final rsp_result.
- Hold rules:
  - req_a/req_b/req_func may change after the accept edge without effect (operands are latched).
  - req_valid held high in RUN/DONE is not accepted until IDLE.

Decomposition:
- Shared package `alu_pkg`:
  - func encoding localparams FUNC_ADD..FUNC_EQ.
  - State encoding ST_IDLE/ST_RUN/ST_DONE.
  - Nibble width constant 4.
- One sub-module `alu4_slice`: combinational 4-bit slice. Inputs a[3:0], b[3:0], cin, func. Outputs y[3:0], cout, c3 (carry into bit 3, for overflow).
- The controller owns the FSM, operand latches, carry register and result assembly.

Test Plan (W=16):
- ADD 0x7FFF+0x0001 -> result 0x8000, cout 0, overflow 1, zero 0; rsp_valid exactly 4 edges after accept.
- SUB 0x0000-0x0001 -> 0xFFFF, cout 0, overflow 0. Then SUB 0x1234-0x1234 -> 0x0000, zero 1, cout 1.
- Compare ops:
  - SLT a=0x8000, b=0x0001 -> 0x0001.
  - SLT a=0x0001, b=0x8000 -> 0x0000.
  - EQ 0xABCD,0xABCD -> 0x0001.
  - EQ 0xABCD,0xABCC -> 0x0000.
- Logic ops:
  - XOR 0xF0F0,0x0FF0 -> 0xFF00.
  - NOT a=0x00FF, b=0x1234 -> 0xFF00, cout 0, overflow 0.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid, with req_valid held 1 and new operands applied.
  - rsp_* stay stable; req_ready stays 0; no second accept.
  - Release rsp_ready -> IDLE next cycle, then the pending request is accepted.
- Reset mid-op: drive rst=0 for one edge after 2 nibbles of ADD 0xFFFF+0x0001.
  - Next cycle: IDLE, rsp_valid 0, busy 0.
  - Following ADD 0x0001+0x0001 -> 0x0002, cout 0 (no stale carry).
